enc_period_quad_sync: RTL
=========================

Name: enc_period_quad_sync

Overview:
- Single-clock quadrature period-measurement block; successor to the per-edge multi-clock period counters.
- Synchronises raw A/B lines, decodes direction, and counts qualified tick_en strobes between consecutive quadrature edges.
- Reports the last quarter-cycle period, the full-cycle period (sum of last 4 quarters), the live running count, and status flags.
- Sits per encoder channel beside the position counter and feeds the velocity-readout register mux.

Parameters:
- CNT_W, 16, width of the running and quarter-period counters; all-ones is the saturation/"stopped" sentinel.
- SYNC_STAGES, 2, synchroniser depth on A and B (legal range ≥2).

Ports:
- clk  in  1  system clock; sole clock.
- reset  in  1  synchronous, active-high reset.
- tick_en  in  1  one-clk strobe at the measurement rate; counters advance only on it.
- a  in  1  raw encoder line A (asynchronous).
- b  in  1  raw encoder line B (asynchronous).
- period_qtr  out  CNT_W  ticks between the last two valid edges.
- period_full  out  CNT_W+2  sum of the last 4 period_qtr values.
- full_valid  out  1  period_full holds 4 same-direction quarters.
- running  out  CNT_W  ticks since the last valid edge (live).
- dir  out  1  1 = A leads B.
- edge_strobe  out  1  one-clk pulse when period_qtr updates.
- dir_chg  out  1  one-clk pulse, coincident with edge_strobe, on a reversal.
- ovf  out  1  last period_qtr was saturated.
- qerr  out  1  sticky; set on an illegal transition (A and B change in the same clk).

Behaviour:
- Reset values:
  - period_qtr = all-ones; period_full = all-ones.
  - running, dir, full_valid, edge_strobe, dir_chg, ovf, qerr = 0.
  - Synchroniser and history cleared; primed = 0.
- Priming:
  - A prime counter suppresses edge detection for SYNC_STAGES+1 clks after reset deasserts.
  - After priming, the previous-sample registers hold the real synced level, so no spurious edge occurs.
- Edge detection on synced a_s/b_s vs previous a_p/b_p:
  - Valid edge: exactly one line changed.
  - Illegal: both changed.
  - Direction of a valid edge: d = a_s XOR b_p.
- Running counter:
  - On tick_en, increments unless at all-ones, where it holds.
  - Cleared to 0 on any valid or illegal edge. Edge has priority; a coincident tick_en is discarded.
- On a valid edge, the following update on the next clk (registered):
  - edge_strobe = 1; dir = d.
  - If d == dir: period_qtr = running, and ovf = (running == all-ones).
  - If d != dir (includes the first edge after reset, since dir resets to 0 and a forward edge differs): period_qtr = all-ones, ovf = 1, dir_chg = 1, history cleared, full_valid = 0.
  - Non-sentinel qtr values are pushed into a 4-deep history; a qualified-entry count saturates at 4.
- Illegal edge: qerr = 1 (sticky until reset); no edge_strobe; period_qtr, dir and history unchanged.
- period_full:
  - Updated 1 clk after edge_strobe (pipelined adder).
  - Value = sum of the 4 history entries.
  - full_valid = 1 when the history holds 4 entries, else 0, with period_full = all-ones.
  - If any entry is all-ones, the sum saturates to all-ones (CNT_W+2).
- Latency:
  - A change on a or b reaches edge_strobe SYNC_STAGES+2 clks later.
  - period_full follows edge_strobe by 1 clk.
- Reset mid-operation: all state returns to reset values in the same clk; re-priming is required before edges are recognised.

Decomposition:
- Shared package enc_pkg:
  - function sat_max(width) returning all-ones;
  - typedef for edge class (NONE, VALID, ILLEGAL);
  - constant DIR_FWD = 1.
- One sub-module, quad_edge_sync: synchroniser, priming, and edge/direction/illegal decode. Outputs edge_valid, edge_illegal, edge_dir.

Test Plan:
- Forward, tick_en every clk, one valid edge every 100 clks (00→10→11→01→…) → period_qtr = 99 from the second edge on, dir = 1; after 4 same-dir edges, period_full = 396 and full_valid = 1.
- Reversal after 6 forward edges (next edge goes backward) → dir_chg pulse, period_qtr = 0xFFFF, ovf = 1, full_valid = 0; 4 backward edges later, full_valid = 1 and period_full = 4×qtr.
- CNT_W = 8, no edges for 300 tick_en → running holds 255; next same-dir edge → period_qtr = 255, ovf = 1, period_full saturates to 0x3FF.
- a and b toggle in the same sample clk → qerr = 1 and stays set, no edge_strobe, running = 0, period_qtr unchanged.
- tick_en asserted in the same clk as the edge is detected → that tick is dropped; with 50 ticks between edges, period_qtr = 49.
- reset pulsed 1 clk mid-stream with a = b = 1 held → all outputs at reset values; no edge_strobe during the SYNC_STAGES+1 clk priming window; the next real edge reports period_qtr = 0xFFFF with dir_chg = 1.

Source files
------------

// File: rtl/enc_pkg.sv
// Shared types and helpers for the quadrature period-measurement block.
package enc_pkg;

    typedef enum logic [1:0] {
        EDGE_NONE    = 2'd0,
        EDGE_VALID   = 2'd1,
        EDGE_ILLEGAL = 2'd2
    } edge_class_t;

    localparam logic DIR_FWD = 1'b1;

    // All-ones of the given width, zero-extended to 32 bits.
    function automatic logic [31:0] sat_max(input int unsigned width);
        return (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    endfunction

endpackage

// File: rtl/quad_edge_sync.sv
// Synchronises raw A/B, primes the previous-sample registers after reset,
// and classifies each clk as no edge, a valid quadrature edge or an illegal one.
module quad_edge_sync
    import enc_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic a,
    input  logic b,
    output logic edge_valid,
    output logic edge_illegal,
    output logic edge_dir
);

    localparam int unsigned PRIME_W = $clog2(SYNC_STAGES + 2);
    localparam logic [PRIME_W-1:0] PRIME_DONE = PRIME_W'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0] a_sync;
    logic [SYNC_STAGES-1:0] b_sync;
    logic                   a_s;
    logic                   b_s;
    logic                   a_p;
    logic                   b_p;
    logic [PRIME_W-1:0]     prime_cnt;
    logic                   primed;
    edge_class_t            edge_class_c;
    logic                   dir_c;

    assign a_s    = a_sync[SYNC_STAGES-1];
    assign b_s    = b_sync[SYNC_STAGES-1];
    assign primed = (prime_cnt == PRIME_DONE);

    // Edge classification; suppressed until a_p/b_p hold real synced levels.
    always_comb begin
        edge_class_c = EDGE_NONE;
        dir_c        = (a_s ^ b_p) ? DIR_FWD : ~DIR_FWD;
        if (primed) begin
            if ((a_s != a_p) && (b_s != b_p)) begin
                edge_class_c = EDGE_ILLEGAL;
            end else if ((a_s != a_p) || (b_s != b_p)) begin
                edge_class_c = EDGE_VALID;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_sync       <= '0;
            b_sync       <= '0;
            a_p          <= 1'b0;
            b_p          <= 1'b0;
            prime_cnt    <= '0;
            edge_valid   <= 1'b0;
            edge_illegal <= 1'b0;
            edge_dir     <= 1'b0;
        end else begin
            a_sync       <= {a_sync[SYNC_STAGES-2:0], a};
            b_sync       <= {b_sync[SYNC_STAGES-2:0], b};
            a_p          <= a_s;
            b_p          <= b_s;
            if (!primed) begin
                prime_cnt <= prime_cnt + PRIME_W'(1);
            end
            edge_valid   <= (edge_class_c == EDGE_VALID);
            edge_illegal <= (edge_class_c == EDGE_ILLEGAL);
            edge_dir     <= dir_c;
        end
    end

endmodule

// File: rtl/enc_period_quad_sync.sv
// Quadrature period measurement: quarter-cycle period, 4-quarter full period,
// live running count, direction and status flags, all on one clock.
module enc_period_quad_sync
    import enc_pkg::*;
#(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick_en,
    input  logic               a,
    input  logic               b,
    output logic [CNT_W-1:0]   period_qtr,
    output logic [CNT_W+1:0]   period_full,
    output logic               full_valid,
    output logic [CNT_W-1:0]   running,
    output logic               dir,
    output logic               edge_strobe,
    output logic               dir_chg,
    output logic               ovf,
    output logic               qerr
);

    localparam int unsigned FULL_W = CNT_W + 2;
    localparam int unsigned HIST_N = 4;
    localparam int unsigned HCNT_W = 3;
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(sat_max(CNT_W));
    localparam logic [FULL_W-1:0] FULL_MAX = FULL_W'(sat_max(FULL_W));

    logic               edge_valid;
    logic               edge_illegal;
    logic               edge_dir;
    logic [CNT_W-1:0]   hist [HIST_N];
    logic [HCNT_W-1:0]  hist_cnt;
    logic [FULL_W-1:0]  sum_c;
    logic               sat_c;
    logic               same_dir_c;
    logic               hist_full_c;

    quad_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge (
        .clk          (clk),
        .reset        (reset),
        .a            (a),
        .b            (b),
        .edge_valid   (edge_valid),
        .edge_illegal (edge_illegal),
        .edge_dir     (edge_dir)
    );

    // Sum of history for the pipelined full-period stage; any saturated entry poisons it.
    always_comb begin
        sum_c       = '0;
        sat_c       = 1'b0;
        same_dir_c  = (edge_dir == dir);
        hist_full_c = (hist_cnt == HCNT_W'(HIST_N));
        for (int unsigned i = 0; i < HIST_N; i++) begin
            sum_c = sum_c + FULL_W'(hist[i]);
            if (hist[i] == CNT_MAX) begin
                sat_c = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            period_qtr  <= CNT_MAX;
            period_full <= FULL_MAX;
            full_valid  <= 1'b0;
            running     <= '0;
            dir         <= 1'b0;
            edge_strobe <= 1'b0;
            dir_chg     <= 1'b0;
            ovf         <= 1'b0;
            qerr        <= 1'b0;
            hist_cnt    <= '0;
            for (int unsigned i = 0; i < HIST_N; i++) begin
                hist[i] <= '0;
            end
        end else begin
            edge_strobe <= 1'b0;
            dir_chg     <= 1'b0;

            // Any edge restarts the count and swallows a coincident tick.
            if (edge_valid || edge_illegal) begin
                running <= '0;
            end else if (tick_en && (running != CNT_MAX)) begin
                running <= running + CNT_W'(1);
            end

            if (edge_illegal) begin
                qerr <= 1'b1;
            end

            if (edge_valid) begin
                edge_strobe <= 1'b1;
                dir         <= edge_dir;
                if (same_dir_c) begin
                    period_qtr <= running;
                    ovf        <= (running == CNT_MAX);
                    hist[0]    <= running;
                    for (int unsigned i = HIST_N - 1; i > 0; i--) begin
                        hist[i] <= hist[i-1];
                    end
                    if (!hist_full_c) begin
                        hist_cnt <= hist_cnt + HCNT_W'(1);
                    end
                end else begin
                    // Reversal: the interval spans a direction change and is meaningless.
                    period_qtr <= CNT_MAX;
                    ovf        <= 1'b1;
                    dir_chg    <= 1'b1;
                    full_valid <= 1'b0;
                    hist_cnt   <= '0;
                    for (int unsigned i = 0; i < HIST_N; i++) begin
                        hist[i] <= '0;
                    end
                end
            end

            if (edge_strobe) begin
                if (hist_full_c) begin
                    full_valid  <= 1'b1;
                    period_full <= sat_c ? FULL_MAX : sum_c;
                end else begin
                    full_valid  <= 1'b0;
                    period_full <= FULL_MAX;
                end
            end
        end
    end

endmodule
